// File: rtl/irq_timer_if.sv
// -----------------------------------------------------------------------------
// irq_timer_if
//   CPU-side register bus for the interval timer / IRQ aggregator at
//   $8010-$801F. Same timing as on-chip RAM/ROM: writes land on the clock
//   edge, read data is registered and valid the cycle after the address.
//
//   cs    : active-high select (address_bus in $8010-$801F)
//   we    : 1 = write, 0 = read
//   addr  : register select, address_bus[3:0]
//   din   : CPU write data
//   dout  : registered read data
// -----------------------------------------------------------------------------
interface irq_timer_if;
  logic       cs;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs, output we, output addr, output din, input dout);
  modport slave  (input cs, input we, input addr, input din, output dout);
endinterface

// File: rtl/irq_timer.sv
// -----------------------------------------------------------------------------
// irq_timer
//   16-bit interval timer with an 8-bit prescaler, merged with the ACIA IRQn
//   line into the 65C02 IRQ input.
//
//   clk      : system clock (phi2 domain)
//   resb     : asynchronous active-low reset
//   bus      : register bus (cs/we/addr/din/dout), slave side
//   ext_irqn : ACIA IRQn, active low, asynchronous to clk
//   irq      : active-high registered IRQ to the CPU
//
//   Register map (addr[3] ignored, registers alias at +8):
//     0 R counter[7:0] (captures counter[15:8] into snap) / W latch[7:0]
//     1 R snap / W latch[15:8] and start
//     2 R/W latch[7:0]     3 R/W latch[15:8]
//     4 R/W CTRL {EIE,TIE,CONT,EN}
//     5 R STATUS {irq,running,0000,ext_active,flag} / W bit0=1 clears flag
//     6 R/W prescaler      7 reads 0
// -----------------------------------------------------------------------------
module irq_timer #(
  parameter logic [15:0] LATCH_RESET    = 16'hFFFF,
  parameter logic [7:0]  PRESCALE_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        resb,
  irq_timer_if.slave  bus,
  input  logic        ext_irqn,
  output logic        irq
);

  typedef enum logic [2:0] {
    REG_CNT_LO   = 3'd0,
    REG_CNT_HI   = 3'd1,
    REG_LATCH_LO = 3'd2,
    REG_LATCH_HI = 3'd3,
    REG_CTRL     = 3'd4,
    REG_STATUS   = 3'd5,
    REG_PRE      = 3'd6,
    REG_NONE     = 3'd7
  } reg_sel_e;

  typedef struct packed {
    logic eie;
    logic tie;
    logic cont;
    logic en;
  } ctrl_t;

  reg_sel_e    sel;
  logic        wr;
  logic        rd;
  logic        wr_start;
  logic        wr_clear;

  logic [15:0] counter;
  logic [15:0] latch;
  logic [7:0]  pre;
  logic [7:0]  pre_cnt;
  logic [7:0]  snap;
  ctrl_t       ctrl;
  logic        running;
  logic        flag;
  logic        ext_sync1;
  logic        ext_sync2;
  logic        ext_active;
  logic        tick;
  logic        underflow;
  logic [7:0]  rd_data;

  assign sel        = reg_sel_e'(bus.addr[2:0]);
  assign wr         = bus.cs & bus.we;
  assign rd         = bus.cs & ~bus.we;
  assign wr_start   = wr && (sel == REG_CNT_HI);
  assign wr_clear   = wr && (sel == REG_STATUS) && bus.din[0];
  assign ext_active = ~ext_sync2;

  // The prescaler only runs while the timer is both enabled and running, so
  // clearing EN freezes pre_cnt and counter together.
  assign tick      = ctrl.en & running & (pre_cnt == 8'd0);
  assign underflow = tick & (counter == 16'd0);

  // Configuration registers.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; blocking assignments here would make
  // the result depend on statement order.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      latch <= LATCH_RESET;
      pre   <= PRESCALE_RESET;
      ctrl  <= '0;
    end else if (wr) begin
      case (sel)
        REG_CNT_LO, REG_LATCH_LO: latch[7:0]  <= bus.din;
        REG_CNT_HI, REG_LATCH_HI: latch[15:8] <= bus.din;
        REG_CTRL:                 ctrl        <= ctrl_t'(bus.din[3:0]);
        REG_PRE:                  pre         <= bus.din;
        default:                  ;
      endcase
    end
  end

  // Counter, prescaler and flag. A start write overrides any same-cycle tick;
  // an underflow overrides a same-cycle STATUS clear. The auto-reload reads
  // the pre-edge latch, so a reg-0 write on that edge is not seen yet.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      counter <= 16'h0000;
      pre_cnt <= 8'h00;
      running <= 1'b0;
      flag    <= 1'b0;
    end else if (wr_start) begin
      counter <= {bus.din, latch[7:0]};
      pre_cnt <= pre;
      running <= 1'b1;
      flag    <= 1'b0;
    end else begin
      if (ctrl.en && running)
        pre_cnt <= (pre_cnt == 8'd0) ? pre : pre_cnt - 8'd1;

      if (tick) begin
        if (counter != 16'd0)
          counter <= counter - 16'd1;
        else if (ctrl.cont)
          counter <= latch;
        else
          running <= 1'b0;
      end

      if (underflow)
        flag <= 1'b1;
      else if (wr_clear)
        flag <= 1'b0;
    end
  end

  // Read mux.
  // NOTE: the default assignment before the case keeps this purely
  // combinational; without it any unlisted path would infer a latch.
  always_comb begin
    rd_data = 8'h00;
    case (sel)
      REG_CNT_LO:   rd_data = counter[7:0];
      REG_CNT_HI:   rd_data = snap;
      REG_LATCH_LO: rd_data = latch[7:0];
      REG_LATCH_HI: rd_data = latch[15:8];
      REG_CTRL:     rd_data = {4'b0000, ctrl};
      REG_STATUS:   rd_data = {irq, running, 4'b0000, ext_active, flag};
      REG_PRE:      rd_data = pre;
      REG_NONE:     rd_data = 8'h00;
      default:      rd_data = 8'h00;
    endcase
  end

  // Registered read data. Reading the low counter byte latches the high byte
  // so a following reg-1 read returns a coherent 16-bit value.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      bus.dout <= 8'h00;
      snap     <= 8'h00;
    end else if (rd) begin
      bus.dout <= rd_data;
      if (sel == REG_CNT_LO)
        snap <= counter[15:8];
    end
  end

  // Two-flop synchroniser for the asynchronous ACIA IRQn; idles high.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      ext_sync1 <= 1'b1;
      ext_sync2 <= 1'b1;
    end else begin
      ext_sync1 <= ext_irqn;
      ext_sync2 <= ext_sync1;
    end
  end

  // Level-sensitive IRQ, registered; drops at once on reset.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb)
      irq <= 1'b0;
    else
      irq <= (flag & ctrl.tie) | (ext_active & ctrl.eie);
  end

endmodule
